// File: rtl/xbar_burst_arbiter_pkg.sv
// rtl/xbar_burst_arbiter_pkg.sv - shared sizes, FSM state type and round-robin search for the crossbar arbiter
package xbar_pkg;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int DW = 2;
  localparam int SW = 2;
  localparam int LW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // First set bit of vec scanning upward from ptr+1, wrapping modulo N.
  function automatic logic [SW-1:0] rr_first(input logic [N-1:0] vec, input logic [SW-1:0] ptr);
    logic [SW-1:0] idx;
    logic          hit;
    rr_first = ptr;
    hit      = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!hit && vec[idx]) begin
        rr_first = idx;
        hit      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/xbar_burst_arbiter_if.sv
// rtl/xbar_burst_arbiter_if.sv - request/grant and permission bus between requesters and the arbiter
interface xbar_burst_arbiter_if;
  import xbar_pkg::*;

  logic [N-1:0]    req;
  logic [N*DW-1:0] dest;
  logic [N*LW-1:0] len;
  logic [N-1:0]    beat_valid;
  logic            perm_we;
  logic [SW-1:0]   perm_idx;
  logic [M-1:0]    perm_data;
  logic [N-1:0]    gnt;
  logic [M*SW-1:0] sel;
  logic [M-1:0]    out_busy;
  logic [N-1:0]    deny;

  modport master (
    output req, dest, len, beat_valid, perm_we, perm_idx, perm_data,
    input  gnt, sel, out_busy, deny
  );

  modport slave (
    input  req, dest, len, beat_valid, perm_we, perm_idx, perm_data,
    output gnt, sel, out_busy, deny
  );

endinterface

// File: rtl/xbar_burst_arbiter_rr_arb.sv
// rtl/xbar_burst_arbiter_rr_arb.sv - single-output round-robin pick from a candidate vector
module xbar_rr_arb
  import xbar_pkg::*;
(
  input  logic [N-1:0]  cand,
  input  logic [SW-1:0] ptr,
  output logic          valid,
  output logic [SW-1:0] pick
);

  assign valid = |cand;
  assign pick  = rr_first(cand, ptr);

endmodule

// File: rtl/xbar_burst_arbiter.sv
// rtl/xbar_burst_arbiter.sv - per-output burst-locking round-robin arbiter with permission filter
module xbar_burst_arbiter
  import xbar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  xbar_burst_arbiter_if.slave bus
);

  logic [M-1:0]  perm_q  [N];
  arb_state_e    state_q [M];
  arb_state_e    state_d [M];
  logic [SW-1:0] sel_q   [M];
  logic [SW-1:0] sel_d   [M];
  logic [SW-1:0] ptr_q   [M];
  logic [SW-1:0] ptr_d   [M];
  logic [LW-1:0] cnt_q   [M];
  logic [LW-1:0] cnt_d   [M];
  logic [N-1:0]  cand    [M];
  logic [SW-1:0] win_idx [M];
  logic [M-1:0]  win_valid;
  logic [N-1:0]  gnt_w;
  logic [N-1:0]  deny_d;
  logic [N-1:0]  deny_q;

  // Grants are decoded from the output FSMs, so reset clears them without a clock.
  always_comb begin
    gnt_w = '0;
    for (int j = 0; j < M; j++) begin
      if (state_q[j] == BUSY) gnt_w[sel_q[j]] = 1'b1;
    end
  end

  always_comb begin
    deny_d = '0;
    for (int j = 0; j < M; j++) begin
      cand[j] = '0;
      for (int i = 0; i < N; i++) begin
        cand[j][i] = bus.req[i] && (bus.dest[i*DW +: DW] == DW'(j)) && perm_q[i][j] && !gnt_w[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      deny_d[i] = bus.req[i] && !perm_q[i][bus.dest[i*DW +: DW]] && !gnt_w[i];
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_out
    xbar_rr_arb u_arb (
      .cand  (cand[j]),
      .ptr   (ptr_q[j]),
      .valid (win_valid[j]),
      .pick  (win_idx[j])
    );
    assign bus.sel[j*SW +: SW] = sel_q[j];
    assign bus.out_busy[j]     = (state_q[j] == BUSY);
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      state_d[j] = state_q[j];
      sel_d[j]   = sel_q[j];
      ptr_d[j]   = ptr_q[j];
      cnt_d[j]   = cnt_q[j];
      case (state_q[j])
        IDLE: begin
          if (win_valid[j]) begin
            state_d[j] = BUSY;
            sel_d[j]   = win_idx[j];
            cnt_d[j]   = bus.len[win_idx[j]*LW +: LW];
          end
        end
        BUSY: begin
          // Dropped request aborts; last beat completes. Either way no arbitration this cycle.
          if (!bus.req[sel_q[j]] || (bus.beat_valid[sel_q[j]] && cnt_q[j] == '0)) begin
            state_d[j] = IDLE;
            ptr_d[j]   = sel_q[j];
          end else if (bus.beat_valid[sel_q[j]]) begin
            cnt_d[j] = cnt_q[j] - 1'b1;
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= IDLE;
        sel_q[j]   <= '0;
        ptr_q[j]   <= SW'(N-1);
        cnt_q[j]   <= '0;
      end
      for (int i = 0; i < N; i++) perm_q[i] <= '1;
      deny_q <= '0;
    end else begin
      for (int j = 0; j < M; j++) begin
        state_q[j] <= state_d[j];
        sel_q[j]   <= sel_d[j];
        ptr_q[j]   <= ptr_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
      if (bus.perm_we) begin
        for (int i = 0; i < N; i++) begin
          if (bus.perm_idx == SW'(i)) perm_q[i] <= bus.perm_data;
        end
      end
      deny_q <= deny_d;
    end
  end

  assign bus.gnt  = gnt_w;
  assign bus.deny = deny_q;

endmodule

// File: doc/xbar_burst_arbiter.md
Name: xbar_burst_arbiter

Overview:
- Per-output arbiter and sequencer for the N x M 32-bit crossbar switch.
- Shares each output port between competing inputs using round-robin arbitration.
- Locks an output to the winning input for a whole burst, then releases it.
- Owns the per-input destination permission masks (the security filter) and drives the crossbar's per-output select and valid.

Parameters:
- N, 4, number of input (requester) ports
- M, 4, number of output ports
- DW, 2, destination field width, equal to clog2(M)
- SW, 2, source select width, equal to clog2(N)
- LW, 4, burst length field width; length is encoded as beats minus 1

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  N  input i requests its destination; held high until the burst completes
- dest  in  N*DW  destination of input i, slice [i*DW +: DW]
- len  in  N*LW  burst length minus 1 for input i
- beat_valid  in  N  input i transfers one data beat this cycle (counted only while granted)
- perm_we  in  1  permission-mask write strobe
- perm_idx  in  SW  input index whose mask is written
- perm_data  in  M  new mask; bit j=1 allows output j
- gnt  out  N  input i currently owns its destination output
- sel  out  M*SW  source input driven onto output j, slice [j*SW +: SW]
- out_busy  out  M  output j locked to a burst
- deny  out  N  registered; input i requests a forbidden output

Behaviour:
Reset (rst_n low, any time, asynchronous):
- gnt=0, sel=0, out_busy=0, deny=0.
- Every permission mask = all ones.
- Every round-robin pointer = N-1, so input 0 has priority first.
- Burst counters = 0.
- A burst in flight is dropped with no completion; outputs are valid from the first edge after rst_n rises.

Per-output FSM j, states IDLE and BUSY:
- IDLE, candidate i requires: req[i], dest[i]==j, perm[i][j]=1, gnt[i]=0.
- Winner = first candidate scanning from ptr_j+1 upward, modulo N.
- On a winner, at the next edge: BUSY, gnt[i]=1, sel_j=i, out_busy[j]=1, cnt_j=len[i].
- Latency: req sampled at edge t gives gnt high after edge t.
- BUSY: dest/len of the owner are ignored. Each beat_valid[owner] decrements cnt_j.
- Normal release: beat_valid[owner] with cnt_j==0. At the next edge: IDLE, gnt[owner]=0, out_busy[j]=0, ptr_j=owner; sel_j holds its last value.
- Abort: req[owner] low while BUSY. Immediate release at the next edge, same updates as normal release.
- No arbitration happens in the release cycle, so there is a minimum 1-cycle bubble between bursts on one output.
- len=0 gives a single-beat burst.

Input rules:
- An input holds at most one grant.
- Requests to a busy output wait, with req held.
- Different outputs arbitrate independently and may grant in the same cycle.

deny:
- deny[i] registered = req[i] & ~perm[i][dest[i]] & ~gnt[i].
- Level signal, no grant is ever issued for it, and the request is dropped from arbitration.

Permission writes:
- Take effect at the next edge.
- Arbitration in the write cycle uses the old masks.
- A write never revokes an in-flight burst; it affects future arbitration only.
- perm_idx >= N is ignored.

Decomposition:
- Shared package xbar_pkg holds:
  - N, M, DW, SW, LW defaults
  - FSM state typedef (IDLE, BUSY)
  - a function for round-robin first-set search from a pointer
- One natural sub-module, xbar_rr_arb: a single-output round-robin pick from an N-bit candidate vector and a pointer.
  - Instantiated M times.
  - FSM, counter and permission registers stay in the top.

Test Plan:
- Reset, then req[0]=1, dest0=2, len0=3, beat_valid0 high every cycle:
  - gnt[0] rises one cycle after req, out_busy[2]=1, sel_2=0.
  - gnt[0] falls after the 4th beat.
- req[0..3] all dest=1, len=0, held:
  - grants go 0,1,2,3,0 in order, one per 2 cycles (bubble), with sel_1 tracking the owner.
- perm_we, perm_idx=2, perm_data=4'b1011, then req[2] to dest 2:
  - deny[2]=1 the next cycle, gnt[2]=0, out_busy[2]=0.
- req[1] to dest 0, len=7; drop req[1] after 2 beats:
  - gnt[1] and out_busy[0] clear on the following edge.
  - A pending req[3] to dest 0 is granted one cycle later.
- req[0] to dest 0 and req[1] to dest 3 in the same cycle:
  - both granted the same edge.
- Assert rst_n low mid-burst:
  - gnt, out_busy and deny go 0 immediately without waiting for a clock edge.
  - Masks restore to all ones; input 0 wins the first contest after reset.
